// File: rtl/excit_timing_gen.sv
// Excitation timing generator: settle, then a 50% Sync square wave with per-measurement
// period index; stops cleanly on a measurement boundary or immediately on Abort.
module excit_timing_gen #(
  parameter int PERIODS    = 8,
  parameter int SETTLE_CYC = 16,
  parameter int DIV_W      = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             StopReq,
  input  logic             Abort,
  input  logic [DIV_W-1:0] HalfDiv,
  output logic             EnExcit,
  output logic             Sync,
  output logic [7:0]       periodCnt,
  output logic             MeasDone,
  output logic             Busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

  localparam logic [7:0]   LAST_PER    = 8'(PERIODS - 1);
  localparam logic [15:0]  LAST_SETTLE = 16'(SETTLE_CYC - 1);
  localparam logic [DIV_W:0] ONE       = (DIV_W+1)'(1);

  state_t           state;
  logic [DIV_W-1:0] h;
  logic [DIV_W:0]   div_cnt;
  logic [DIV_W:0]   div_nxt;
  logic [DIV_W:0]   div_last;
  logic [DIV_W:0]   h_ext;
  logic [15:0]      settle_cnt;
  logic             stop_pend;
  logic             go_idle;

  assign h_ext    = {1'b0, h};
  assign div_last = {h, 1'b0} - ONE;
  assign div_nxt  = div_cnt + ONE;

  // Measurement boundary: periodCnt already wrapped to 0 at the last falling edge.
  always_comb begin
    go_idle = 1'b0;
    if (Abort)
      go_idle = 1'b1;
    else if (state == SETTLE && StopReq)
      go_idle = 1'b1;
    else if (state == RUN && div_cnt == div_last && stop_pend && periodCnt == 8'd0)
      go_idle = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst || go_idle) begin
      state      <= IDLE;
      h          <= '0;
      div_cnt    <= '0;
      settle_cnt <= '0;
      stop_pend  <= 1'b0;
      EnExcit    <= 1'b0;
      Sync       <= 1'b0;
      periodCnt  <= 8'd0;
      MeasDone   <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      MeasDone <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            h          <= (HalfDiv == '0) ? DIV_W'(1) : HalfDiv;
            settle_cnt <= '0;
            state      <= SETTLE;
            EnExcit    <= 1'b1;
            Busy       <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == LAST_SETTLE) begin
            state   <= RUN;
            div_cnt <= '0;
            Sync    <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 16'd1;
          end
        end
        RUN: begin
          if (StopReq)
            stop_pend <= 1'b1;
          if (div_cnt == div_last) begin
            div_cnt <= '0;
            Sync    <= 1'b1;
          end else begin
            div_cnt <= div_nxt;
            Sync    <= (div_nxt < h_ext);
            if (div_nxt == h_ext) begin
              if (periodCnt == LAST_PER) begin
                periodCnt <= 8'd0;
                MeasDone  <= 1'b1;
              end else begin
                periodCnt <= periodCnt + 8'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_excit_timing_gen.sv
// Bench for excit_timing_gen (PERIODS=4, SETTLE_CYC=5): expected per-cycle outputs are queued
// as stimulus is planned and compared one entry per clock, #1 after the rising edge.
module tb_excit_timing_gen;

  localparam int P  = 4;
  localparam int SC = 5;

  logic        Clk;
  logic        Rst, Start, StopReq, Abort;
  logic [15:0] HalfDiv;
  logic        EnExcit, Sync, MeasDone, Busy;
  logic [7:0]  periodCnt;

  typedef struct packed {
    logic       en;
    logic       sync;
    logic [7:0] pc;
    logic       md;
    logic       busy;
  } exp_t;

  typedef struct {
    logic        rst, start, stop, abort;
    logic [15:0] hd;
    exp_t        exp;
  } vec_t;

  exp_t  sb[$];
  int    errors = 0;
  int    checks = 0;
  string tag    = "init";

  excit_timing_gen #(.PERIODS(P), .SETTLE_CYC(SC), .DIV_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .StopReq(StopReq), .Abort(Abort),
    .HalfDiv(HalfDiv), .EnExcit(EnExcit), .Sync(Sync), .periodCnt(periodCnt),
    .MeasDone(MeasDone), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic push(input logic en, sync, input logic [7:0] pc, input logic md, busy);
    exp_t e;
    e.en = en; e.sync = sync; e.pc = pc; e.md = md; e.busy = busy;
    sb.push_back(e);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic push_settle(input int n);
    for (int i = 0; i < n; i++) push(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
  endtask

  // n whole Sync periods of half-period h; index advances and wraps on the falling edge
  task automatic push_periods(input int h, input int pc0, input int n);
    int pc, pcn;
    pc = pc0;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < h; c++) push(1'b1, 1'b1, 8'(pc), 1'b0, 1'b1);
      pcn = (pc == P - 1) ? 0 : pc + 1;
      for (int c = 0; c < h; c++) push(1'b1, 1'b0, 8'(pcn), (c == 0 && pcn == 0), 1'b1);
      pc = pcn;
    end
  endtask

  task automatic check();
    exp_t e, a;
    a.en = EnExcit; a.sync = Sync; a.pc = periodCnt; a.md = MeasDone; a.busy = Busy;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got en=%b sync=%b pc=%0d md=%b busy=%b",
               tag, a.en, a.sync, a.pc, a.md, a.busy);
    end else begin
      e = sb.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s @%0t: got en=%b sync=%b pc=%0d md=%b busy=%b, want en=%b sync=%b pc=%0d md=%b busy=%b",
                 tag, $time, a.en, a.sync, a.pc, a.md, a.busy, e.en, e.sync, e.pc, e.md, e.busy);
      end
    end
  endtask

  task automatic cyc(input logic rst, start, stop, abort, input logic [15:0] hd);
    Rst = rst; Start = start; StopReq = stop; Abort = abort; HalfDiv = hd;
    @(posedge Clk);
    #1;
    Rst = 1'b0; Start = 1'b0; StopReq = 1'b0; Abort = 1'b0;
    check();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, HalfDiv);
  endtask

  vec_t vecs[5];
  exp_t e_idle, e_set;

  initial begin
    Rst = 1'b1; Start = 1'b0; StopReq = 1'b0; Abort = 1'b0; HalfDiv = 16'd0;
    e_idle = '{en: 1'b0, sync: 1'b0, pc: 8'd0, md: 1'b0, busy: 1'b0};
    e_set  = '{en: 1'b1, sync: 1'b0, pc: 8'd0, md: 1'b0, busy: 1'b1};

    vecs[0] = '{rst: 1'b1, start: 1'b0, stop: 1'b0, abort: 1'b0, hd: 16'd4, exp: e_idle};
    vecs[1] = '{rst: 1'b1, start: 1'b1, stop: 1'b0, abort: 1'b0, hd: 16'd4, exp: e_idle};
    vecs[2] = '{rst: 1'b0, start: 1'b0, stop: 1'b1, abort: 1'b0, hd: 16'd4, exp: e_idle};
    vecs[3] = '{rst: 1'b0, start: 1'b1, stop: 1'b0, abort: 1'b1, hd: 16'd4, exp: e_idle};
    vecs[4] = '{rst: 1'b0, start: 1'b1, stop: 1'b0, abort: 1'b0, hd: 16'd4, exp: e_set};

    tag = "reset_prec";
    for (int i = 0; i < 5; i++) begin
      sb.push_back(vecs[i].exp);
      cyc(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].abort, vecs[i].hd);
    end

    // basic run: settle then H=4 periods, five of them crossing one measurement wrap
    tag = "run_h4";
    push_settle(SC - 1);
    push_periods(4, 0, 5);
    run(SC - 1 + 5 * 8);

    // StopReq during index 1: finish indices 1..3, then idle
    tag = "stop_boundary";
    push_periods(4, 1, 3);
    push_idle(3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'd4);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'd4);
    run(25);

    tag = "stop_in_settle";
    push_settle(2);
    push_idle(2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'd4);
    run(1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'd4);
    run(1);

    tag = "halfdiv_zero";
    push_settle(SC);
    push_periods(1, 0, 6);
    push_idle(2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    run(SC - 1 + 12);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    run(1);

    tag = "abort_high";
    push_settle(SC);
    push_periods(4, 0, 1);
    push(1'b1, 1'b1, 8'd1, 1'b0, 1'b1);
    push(1'b1, 1'b1, 8'd1, 1'b0, 1'b1);
    push_idle(3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'd4);
    run(SC - 1 + 8 + 2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'd4);
    run(2);

    // rerun after abort; Start with HalfDiv=8 while busy must be ignored
    tag = "busy_start";
    push_settle(SC);
    push_periods(4, 0, 2);
    push_idle(2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'd4);
    run(1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'd8);
    run(10);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'd8);
    run(7);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'd8);
    run(1);

    // Rst together with StopReq: the pending stop must not survive into the next run
    tag = "rst_with_stop";
    push_settle(SC);
    push_periods(2, 0, 1);
    push(1'b1, 1'b1, 8'd1, 1'b0, 1'b1);
    push_idle(1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
    run(SC - 1 + 4 + 1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'd2);
    tag = "rerun_after_rst";
    push_settle(SC);
    push_periods(2, 0, 6);
    push_idle(2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
    run(SC - 1 + 24);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'd2);
    run(1);

    tag = "drain";
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected entries left, want 0", tag, sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/excit_timing_gen.md
Name: excit_timing_gen

Overview:
- Excitation timing generator directly upstream of the switch-array sequencer.
- Produces the excitation enable (EnExcit), the Sync square wave and the per-measurement period index (periodCnt) that the switch-array sequencer consumes to step switch addresses and flag frame end.
- Runs a start/settle/run/drain sequence so electrode switching and excitation start and stop cleanly on measurement boundaries.

Parameters:
- PERIODS, 8, Sync periods per measurement; legal range 1..255; periodCnt counts 0..PERIODS-1.
- SETTLE_CYC, 16, Clk cycles EnExcit is held high with Sync low before the first Sync rise (switch settle time); legal range 1..65535.
- DIV_W, 16, width of the half-period divider input and counter.

Ports:
- Clk  input  1  system clock.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  single-cycle request to begin excitation.
- StopReq  input  1  single-cycle request to stop at the next measurement boundary.
- Abort  input  1  immediate stop, sampled every cycle.
- HalfDiv  input  DIV_W  Clk cycles per Sync half-period; latched on accepted Start; value 0 is treated as 1.
- EnExcit  output  1  excitation enable to the switch-array sequencer.
- Sync  output  1  registered square wave, 50% duty, period 2*H Clk cycles, where H is the latched HalfDiv.
- periodCnt  output  8  period index within the current measurement.
- MeasDone  output  1  one-Clk pulse when periodCnt wraps to 0.
- Busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (Rst=1 at a Clk edge): state=IDLE, EnExcit=0, Sync=0, periodCnt=0, MeasDone=0, Busy=0, stop-pending flag cleared, all counters 0.
- All outputs are registered. No combinational path from inputs to outputs.
- IDLE:
  - EnExcit=0, Sync=0, periodCnt=0.
  - Start=1 latches H=max(HalfDiv,1), clears the settle counter and moves to SETTLE on the next cycle.
- SETTLE:
  - EnExcit=1, Busy=1, Sync=0.
  - Settle counter counts SETTLE_CYC cycles, then moves to RUN with divCnt=0.
- RUN:
  - divCnt counts 0..2H-1 and wraps.
  - Sync=1 while divCnt<H, Sync=0 while divCnt>=H. The first RUN cycle has Sync=1, which is the first rising edge, with periodCnt=0.
  - At the cycle divCnt==H (Sync falling): periodCnt <= (periodCnt==PERIODS-1) ? 0 : periodCnt+1. MeasDone=1 for that single cycle when the wrap occurs.
  - periodCnt therefore changes only mid-period and is stable for H cycles before and after every Sync rising edge.
- StopReq:
  - Accepted in SETTLE or RUN; sets stop-pending.
  - In SETTLE, the block goes to IDLE on the next cycle.
  - In RUN, when divCnt==2H-1, stop-pending=1 and periodCnt==0 (the measurement just completed), the block goes to IDLE instead of producing the next rise. The last measurement always contains exactly PERIODS Sync rises.
- Abort: any state goes to IDLE on the next cycle. Outputs take IDLE values and stop-pending clears.
- Precedence: Rst > Abort > StopReq > Start.
- Start while Busy is ignored, and HalfDiv is not re-latched. HalfDiv changes while Busy have no effect.
- StopReq in IDLE is ignored.
- PERIODS=1: periodCnt stays 0 and MeasDone pulses every Sync period.
- Reset mid-operation: identical to power-up reset, taking effect on the same edge.
- Arithmetic:
  - 2H-1 is computed in DIV_W+1 bits; no overflow for H up to 2^DIV_W-1.
  - Settle counter is 16 bits.
  - periodCnt comparisons use the 8-bit PERIODS-1.

Test Plan:
- Reset, then Start with HalfDiv=4, PERIODS=4, SETTLE_CYC=5 -> EnExcit rises 1 cycle after Start; Sync stays 0 for 5 cycles, then toggles 4 high / 4 low; periodCnt is 0,1,2,3,0 changing on Sync falling edges; MeasDone pulses once every 32 cycles.
- HalfDiv=0 on Start -> Sync period is 2 cycles (1 high, 1 low); periodCnt still steps once per period.
- StopReq during period index 1 -> Sync completes rises for indices 2 and 3, ends low; IDLE entered after divCnt==7 of the last period; EnExcit=0, Busy=0, periodCnt=0.
- Abort in the middle of a Sync high phase -> next cycle Sync=0, EnExcit=0, periodCnt=0, Busy=0; a later Start rerun shows full SETTLE_CYC settle again.
- Start pulse while Busy with a different HalfDiv=8 -> no change to the period (stays 8 cycles) and no restart of SETTLE.
- Rst asserted during RUN in the same cycle as StopReq -> all outputs at reset values next cycle; the stop-pending flag is not retained into the next run.
